// File: rtl/proj_qsys_nios2_qsys_0_oci_dct_packer.sv
// OCI debug-trace packer: packs SYM_W-bit symbols LSB-first into a frame, hands frames off over valid/ready.
// Optional idle auto-flush is enabled by defining NIOS2_OCI_DCT_IDLE_FLUSH_EN.
module proj_qsys_nios2_qsys_0_oci_dct_packer #(
    parameter int SYM_W       = 3,
    parameter int NUM_SYM     = 10,
    parameter int IDLE_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sym_valid,
    input  logic [SYM_W-1:0]         sym_data,
    output logic                     sym_ready,
    input  logic                     flush,
    input  logic                     end_req,
    output logic                     frame_valid,
    output logic [SYM_W*NUM_SYM-1:0] frame_data,
    output logic [3:0]               frame_cnt,
    input  logic                     frame_ready,
    output logic [SYM_W*NUM_SYM-1:0] dct_buffer,
    output logic [3:0]               dct_count,
    output logic                     test_ending,
    output logic                     test_has_ended
);
    localparam int FW = SYM_W * NUM_SYM;
    localparam logic [3:0] FULL = 4'(NUM_SYM);

    typedef enum logic [1:0] {S_RUN, S_ENDING, S_ENDED} state_t;

    state_t          r_state;
    logic [FW-1:0]   r_buf;
    logic [3:0]      r_cnt;
    logic            r_fvalid;
    logic [FW-1:0]   r_fdata;
    logic [3:0]      r_fcnt;
    logic            r_flush_pend;
    logic            r_ending;
    logic            r_ended;

    logic            w_slot_free;
    logic            w_emit;
    logic            w_accept;
    logic            w_idle_hit;
    logic [FW-1:0]   w_nbuf;
    logic [3:0]      w_base_cnt;
    logic [3:0]      w_ncnt;
    logic            w_fp_next;

    assign w_slot_free = !r_fvalid || frame_ready;
    assign w_emit      = w_slot_free && ((r_cnt == FULL) || (r_flush_pend && r_cnt != 4'd0));
    // Reset gating keeps every output low while reset is held
    assign sym_ready   = !reset && (r_state == S_RUN) && ((r_cnt < FULL) || w_slot_free);
    assign w_accept    = sym_valid && sym_ready;

`ifdef NIOS2_OCI_DCT_IDLE_FLUSH_EN
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    logic [IW-1:0] r_idle;

    // Fires on the cycle the counter reaches IDLE_CYCLES, so flush_pend is set that same edge
    assign w_idle_hit = !w_accept && !w_emit && (r_cnt != 4'd0) &&
                        (r_idle == IW'(IDLE_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_idle <= '0;
        else if (w_accept || w_emit || r_cnt == 4'd0)
            r_idle <= '0;
        else if (r_idle != IW'(IDLE_CYCLES))
            r_idle <= r_idle + IW'(1);
    end
`else
    assign w_idle_hit = 1'b0;
`endif

    always_comb begin
        w_nbuf     = w_emit ? '0 : r_buf;
        w_base_cnt = w_emit ? 4'd0 : r_cnt;
        w_ncnt     = w_base_cnt;
        if (w_accept) begin
            for (int i = 0; i < NUM_SYM; i++)
                if (w_base_cnt == 4'(i))
                    w_nbuf[i*SYM_W +: SYM_W] = sym_data;
            w_ncnt = w_base_cnt + 4'd1;
        end
    end

    always_comb begin
        w_fp_next = r_flush_pend;
        if (w_emit || r_cnt == 4'd0)
            w_fp_next = 1'b0;
        if (r_state == S_RUN && (flush || end_req))
            w_fp_next = 1'b1;
        if (w_idle_hit)
            w_fp_next = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf        <= '0;
            r_cnt        <= 4'd0;
            r_fvalid     <= 1'b0;
            r_fdata      <= '0;
            r_fcnt       <= 4'd0;
            r_flush_pend <= 1'b0;
        end else begin
            r_buf        <= w_nbuf;
            r_cnt        <= w_ncnt;
            r_flush_pend <= w_fp_next;
            if (w_emit) begin
                r_fvalid <= 1'b1;
                r_fdata  <= r_buf;
                r_fcnt   <= r_cnt;
            end else if (frame_ready) begin
                r_fvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_RUN;
            r_ending <= 1'b0;
            r_ended  <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: if (end_req) begin
                    r_state  <= S_ENDING;
                    r_ending <= 1'b1;
                end
                S_ENDING: if (r_cnt == 4'd0 && !r_fvalid) begin
                    r_state <= S_ENDED;
                    r_ended <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign frame_valid    = r_fvalid;
    assign frame_data     = r_fdata;
    assign frame_cnt      = r_fcnt;
    assign dct_buffer     = r_buf;
    assign dct_count      = r_cnt;
    assign test_ending    = r_ending;
    assign test_has_ended = r_ended;
endmodule

// File: doc/proj_qsys_nios2_qsys_0_oci_dct_packer.md
Name: proj_qsys_nios2_qsys_0_oci_dct_packer

Overview:
Upstream producer for the OCI trace test bench. Packs compressed debug-trace symbols LSB-first into a 30-bit frame buffer. Hands full or flushed frames to the trace store over a valid/ready handshake. Drives dct_buffer/dct_count continuously and sequences test_ending/test_has_ended for end-of-test drain.

Parameters:
SYM_W, 3, bits per trace symbol
NUM_SYM, 10, symbols per frame; SYM_W*NUM_SYM must equal 30
IDLE_CYCLES, 16, idle cycles before auto-flush (used only with the optional feature), must be >=1

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
sym_valid  in  1  trace symbol offered
sym_data  in  SYM_W  trace symbol value
sym_ready  out  1  symbol accepted when sym_valid&&sym_ready
flush  in  1  pulse: emit partial buffer
end_req  in  1  pulse: begin end-of-test drain
frame_valid  out  1  frame slot holds a frame
frame_data  out  30  packed frame
frame_cnt  out  4  symbols in frame_data (1..NUM_SYM)
frame_ready  in  1  downstream consumes frame
dct_buffer  out  30  live packing buffer
dct_count  out  4  live fill count 0..NUM_SYM
test_ending  out  1  drain in progress or complete
test_has_ended  out  1  drain complete, sticky

Behaviour:
- Interface: single clock clk; reset asynchronous, active-high. All outputs 0 at reset; state RUN; flush_pend=0.
- Packing: accepted symbol goes to dct_buffer[SYM_W*k+SYM_W-1 : SYM_W*k], k=dct_count; dct_count increments. Unused bits stay 0.
- slot_free = !frame_valid || frame_ready.
- Emit condition: slot_free && (dct_count==NUM_SYM || (flush_pend && dct_count>0)). On emit: frame_data<=dct_buffer, frame_cnt<=dct_count, frame_valid<=1; buffer cleared. Latency: full buffer to frame_valid is 1 cycle if the slot is free.
- Symbol accepted in the emit cycle lands at position 0; dct_count becomes 1.
- sym_ready = (state==RUN) && (dct_count<NUM_SYM || slot_free). Combinational; no dependence on sym_valid.
- frame_valid clears on frame_ready unless a new emit occurs the same cycle, in which case it stays 1 with new data.
- flush pulse sets flush_pend. flush_pend clears on emit, or immediately if dct_count==0. flush during a full-buffer stall is harmless.
- States:
  - RUN: end_req -> ENDING; set flush_pend.
  - ENDING: sym_ready=0; continue emitting. When dct_count==0 && !frame_valid -> ENDED.
  - ENDED: terminal until reset; ignores sym_valid, flush and end_req.
- test_ending=1 in ENDING and ENDED. test_has_ended=1 in ENDED only. Both registered.
- Simultaneous end_req and an accepted symbol: the symbol is packed, then drained.
- Reset mid-frame discards the buffer and frame slot.

Optional Feature:
Macro NIOS2_OCI_DCT_IDLE_FLUSH_EN.
- Defined: an idle counter counts cycles with no accepted symbol while dct_count>0. It resets on accept or emit. At IDLE_CYCLES it sets flush_pend.
- Undefined: no counter; partial frames leave only via flush or end_req.

Test Plan:
- 10 symbols 0..7,0,1 back-to-back, frame_ready=1 -> frame_valid 1 cycle after 10th accept; frame_data=30'o1076543210, frame_cnt=10; dct_count back to 0.
- 3 symbols (5,6,7) then flush -> frame_data=30'o765, frame_cnt=3, frame_valid next cycle.
- frame_ready=0, 20 symbols offered -> 10 accepted into the frame slot, 10 more fill the buffer, then sym_ready=0. Raise frame_ready -> refill continues with no loss or reordering.
- 4 symbols, end_req, frame_ready=1 -> test_ending next cycle; 4-symbol frame emitted; test_has_ended once dct_count=0 and frame_valid=0; sym_ready stays 0.
- Assert reset with dct_count=7 and frame_valid=1 -> all outputs 0 immediately (async); state RUN after release.
- With NIOS2_OCI_DCT_IDLE_FLUSH_EN, IDLE_CYCLES=16: 2 symbols then idle -> auto-flush frame with frame_cnt=2, 17 cycles after last accept. Without the macro, no frame appears.
